gmux_hsck_ctrl: RTL and testbench
=================================

GMUX_HSCK_CTRL -- requirements
Module: gmux_hsck_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the wait-counter width in bits.
REQ-002 Parameter OFF_CYC, default 4, SHALL set the number of cycles quadrants stay gated before SSEL changes; legal range 1..2^CNT_W-1.
REQ-003 Parameter SETTLE_CYC, default 4, SHALL set the number of cycles SSEL settles before quadrants are re-enabled; legal range 1..2^CNT_W-1.
REQ-004 Port CLK  input  1  SHALL be the single clock.
REQ-005 Port RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port SW_REQ  input  1  SHALL be the switch request, sampled on CLK.
REQ-007 Port SEL_REQ  input  1  SHALL be the target source: 0 = GCLKIN, 1 = GHSCK.
REQ-008 Port QMASK  input  4  SHALL be the target quadrant enables, bit order {TL,TR,BL,BR} = [3:0].
REQ-009 Port LP_REQ  input  1  SHALL be the low-power request, level-sensitive.
REQ-010 Port SSEL  output  1  SHALL drive GMUX_HSCK SSEL.
REQ-011 Port SEN  output  4  SHALL drive {TL,TR,BL,BR}_SEN.
REQ-012 Port DEN  output  4  SHALL drive {TL,TR,BL,BR}_DEN; constant 0.
REQ-013 Port DYNEN  output  4  SHALL drive {TL,TR,BL,BR}_DYNEN; constant 0.
REQ-014 Port VLP  output  4  SHALL drive {TL,TR,BL,BR}_VLP.
REQ-015 Port BUSY  output  1  SHALL be high whenever the FSM is outside IDLE.
REQ-016 Port ACK  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-017 All outputs SHALL be registered; the states SHALL be IDLE, WAIT_OFF, WAIT_SET, LP_ENTER, LP, LP_EXIT.
REQ-018 In IDLE with SW_REQ=1, the block SHALL latch SEL_REQ and QMASK as the target (tgt_sel, tgt_mask).
REQ-019 If tgt_sel = SSEL: SEN SHALL load tgt_mask directly, ACK SHALL assert at the next edge (no gating), and the FSM SHALL stay in IDLE.
REQ-020 Otherwise, at request edge E0: SEN SHALL go to 0, the counter SHALL load OFF_CYC-1, BUSY SHALL go to 1, and the FSM SHALL enter WAIT_OFF.
REQ-021 WAIT_OFF SHALL decrement the counter each cycle; at cnt=0 SSEL SHALL load tgt_sel, the counter SHALL load SETTLE_CYC-1, and the FSM SHALL enter WAIT_SET. SSEL therefore changes at edge E0+OFF_CYC.
REQ-022 WAIT_SET SHALL decrement the counter; at cnt=0, at edge E0+OFF_CYC+SETTLE_CYC: SEN SHALL load tgt_mask, ACK SHALL go to 1, BUSY SHALL go to 0, and the FSM SHALL return to IDLE. ACK SHALL clear at the following edge.
REQ-023 SSEL SHALL change only while SEN=0 and VLP=0 (glitch-free switch guarantee).
REQ-024 SW_REQ and SEL_REQ/QMASK changes SHALL be ignored while BUSY=1 and while in LP.
REQ-025 When SW_REQ=1 and LP_REQ=1 in the same IDLE cycle, SW_REQ SHALL win; LP entry SHALL be evaluated on the next IDLE cycle.
REQ-026 In IDLE with LP_REQ=1 and SW_REQ=0: the block SHALL save SEN to lp_mask, set SEN=0, load the counter with OFF_CYC-1, and enter LP_ENTER.
REQ-027 At cnt=0 in LP_ENTER, VLP SHALL go to 4'b1111 and the FSM SHALL enter LP; BUSY SHALL stay 1 throughout LP.
REQ-028 In LP with LP_REQ=0: VLP SHALL go to 0, the counter SHALL load SETTLE_CYC-1, and the FSM SHALL enter LP_EXIT.
REQ-029 At cnt=0 in LP_EXIT, SEN SHALL load lp_mask, ACK SHALL pulse, and the FSM SHALL go to IDLE.
REQ-030 LP_REQ deasserting during LP_ENTER SHALL NOT abort entry; exit SHALL follow through LP.
REQ-031 A request with QMASK=0 SHALL run the full sequence and end with SEN=0.
REQ-032 DEN and DYNEN SHALL be tied 0 (static-enable mode only).

Reset
REQ-033 When RST=1 at an edge, the block SHALL set the state to IDLE, SSEL=0, SEN=0, VLP=0, DEN=0, DYNEN=0, BUSY=0, ACK=0, the counter to 0, and tgt_sel/tgt_mask/lp_mask to 0.
REQ-034 Reset mid-sequence SHALL abandon the operation with no ACK and apply the reset values at that edge.

Verification
REQ-035 The bench SHALL cover: reset, then SW_REQ=1, SEL_REQ=1, QMASK=4'hF at edge 0 -> SEN=0 after edge 0; SSEL=1 after edge 4; SEN=4'hF and ACK=1 after edge 8; ACK=0 after edge 9.
REQ-036 The bench SHALL cover: with SSEL=1, SW_REQ=1, SEL_REQ=1, QMASK=4'h5 -> SEN=4'h5 and ACK=1 after the next edge; SSEL and BUSY never toggle.
REQ-037 The bench SHALL cover: SW_REQ pulsed at edge 2 of a running switch -> ignored; exactly one ACK at edge 8.
REQ-038 The bench SHALL cover: LP_REQ=1 with SEN=4'hA -> SEN=0 at edge 0, VLP=4'hF at edge 4; LP_REQ=0 -> VLP=0, then SEN=4'hA and ACK after 4 more edges.
REQ-039 The bench SHALL cover: RST=1 at edge 5 of a switch -> all outputs at reset values after that edge, no ACK.
REQ-040 The bench SHALL cover: SW_REQ=1 and LP_REQ=1 in the same cycle -> switch completes first, LP entry starts in the first IDLE cycle after ACK.

Source files
------------

// File: rtl/gmux_hsck_ctrl.sv
// Glitch-free GMUX_HSCK source-select sequencer: gates quadrant enables around
// every SSEL change and handles low-power entry/exit with mask save/restore.
module gmux_hsck_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned OFF_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW_REQ,
  input  logic       SEL_REQ,
  input  logic [3:0] QMASK,
  input  logic       LP_REQ,
  output logic       SSEL,
  output logic [3:0] SEN,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP,
  output logic       BUSY,
  output logic       ACK
);

  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OFF = 3'd1,
    WAIT_SET = 3'd2,
    LP_ENTER = 3'd3,
    LP       = 3'd4,
    LP_EXIT  = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             tgt_sel, tgt_sel_d;
  logic [3:0]       tgt_mask, tgt_mask_d;
  logic [3:0]       lp_mask, lp_mask_d;
  logic             ssel_d, busy_d, ack_d;
  logic [3:0]       sen_d, vlp_d;
  logic             cnt_zero;

  // Static-enable mode only: divider and dynamic enables are never used.
  assign DEN   = 4'b0000;
  assign DYNEN = 4'b0000;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      tgt_sel  <= 1'b0;
      tgt_mask <= 4'b0000;
      lp_mask  <= 4'b0000;
      SSEL     <= 1'b0;
      SEN      <= 4'b0000;
      VLP      <= 4'b0000;
      BUSY     <= 1'b0;
      ACK      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      tgt_sel  <= tgt_sel_d;
      tgt_mask <= tgt_mask_d;
      lp_mask  <= lp_mask_d;
      SSEL     <= ssel_d;
      SEN      <= sen_d;
      VLP      <= vlp_d;
      BUSY     <= busy_d;
      ACK      <= ack_d;
    end
  end

  // Next-state and next-output logic; SSEL only moves while SEN and VLP are 0.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    tgt_sel_d  = tgt_sel;
    tgt_mask_d = tgt_mask;
    lp_mask_d  = lp_mask;
    ssel_d     = SSEL;
    sen_d      = SEN;
    vlp_d      = VLP;
    busy_d     = BUSY;
    ack_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (SW_REQ) begin
          tgt_sel_d  = SEL_REQ;
          tgt_mask_d = QMASK;
          if (SEL_REQ == SSEL) begin
            sen_d = QMASK;
            ack_d = 1'b1;
          end else begin
            sen_d   = 4'b0000;
            cnt_d   = OFF_LOAD;
            busy_d  = 1'b1;
            state_d = WAIT_OFF;
          end
        end else if (LP_REQ) begin
          lp_mask_d = SEN;
          sen_d     = 4'b0000;
          cnt_d     = OFF_LOAD;
          busy_d    = 1'b1;
          state_d   = LP_ENTER;
        end
      end
      WAIT_OFF: begin
        if (cnt_zero) begin
          ssel_d  = tgt_sel;
          cnt_d   = SETTLE_LOAD;
          state_d = WAIT_SET;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      WAIT_SET: begin
        if (cnt_zero) begin
          sen_d   = tgt_mask;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      LP_ENTER: begin
        if (cnt_zero) begin
          vlp_d   = 4'b1111;
          state_d = LP;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      LP: begin
        if (!LP_REQ) begin
          vlp_d   = 4'b0000;
          cnt_d   = SETTLE_LOAD;
          state_d = LP_EXIT;
        end
      end
      LP_EXIT: begin
        if (cnt_zero) begin
          sen_d   = lp_mask;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gmux_hsck_ctrl.sv
// Directed bench for gmux_hsck_ctrl: per-edge expected outputs are queued as
// stimulus is applied and popped/compared one edge later.
module tb_gmux_hsck_ctrl;

  logic       CLK;
  logic       RST;
  logic       SW_REQ;
  logic       SEL_REQ;
  logic [3:0] QMASK;
  logic       LP_REQ;
  logic       SSEL;
  logic [3:0] SEN;
  logic [3:0] DEN;
  logic [3:0] DYNEN;
  logic [3:0] VLP;
  logic       BUSY;
  logic       ACK;

  gmux_hsck_ctrl #(
    .CNT_W      (8),
    .OFF_CYC    (4),
    .SETTLE_CYC (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW_REQ  (SW_REQ),
    .SEL_REQ (SEL_REQ),
    .QMASK   (QMASK),
    .LP_REQ  (LP_REQ),
    .SSEL    (SSEL),
    .SEN     (SEN),
    .DEN     (DEN),
    .DYNEN   (DYNEN),
    .VLP     (VLP),
    .BUSY    (BUSY),
    .ACK     (ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic       ssel;
    logic [3:0] sen;
    logic [3:0] vlp;
    logic       busy;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic push(input string tag, input logic ssel, input logic [3:0] sen,
                      input logic [3:0] vlp, input logic busy, input logic ack);
    exp_t e;
    e.tag  = tag;
    e.ssel = ssel;
    e.sen  = sen;
    e.vlp  = vlp;
    e.busy = busy;
    e.ack  = ack;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [3:0] obs,
                     input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  // Advance one edge, then compare every output against the queued entry.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard observed=empty_queue expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, "ssel",  4'(SSEL),  4'(e.ssel));
      chk(e.tag, "sen",   SEN,       e.sen);
      chk(e.tag, "vlp",   VLP,       e.vlp);
      chk(e.tag, "busy",  4'(BUSY),  4'(e.busy));
      chk(e.tag, "ack",   4'(ACK),   4'(e.ack));
      chk(e.tag, "den",   DEN,       4'h0);
      chk(e.tag, "dynen", DYNEN,     4'h0);
    end
  endtask

  task automatic idle_edge(input string tag, input logic ssel, input logic [3:0] sen);
    SW_REQ = 1'b0;
    LP_REQ = 1'b0;
    push(tag, ssel, sen, 4'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic fast_switch(input string tag, input logic sel, input logic [3:0] mask);
    SW_REQ  = 1'b1;
    SEL_REQ = sel;
    QMASK   = mask;
    push(tag, sel, mask, 4'h0, 1'b0, 1'b1);
    tick();
    SW_REQ = 1'b0;
  endtask

  // Gated switch edges 0..8; optional ignored re-request, reset, or held LP_REQ.
  task automatic do_switch(input string tag, input logic sel, input logic [3:0] mask,
                           input int pulse_at, input int rst_at, input logic lp);
    logic old;
    old = ~sel;
    for (int e = 0; e <= 8; e++) begin
      SW_REQ  = (e == 0) || (e == pulse_at);
      SEL_REQ = (e == pulse_at) ? ~sel : sel;
      QMASK   = (e == pulse_at) ? ~mask : mask;
      LP_REQ  = lp;
      if (e == rst_at) begin
        RST = 1'b1;
        push($sformatf("%s_rst%0d", tag, e), 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        RST    = 1'b0;
        SW_REQ = 1'b0;
        LP_REQ = 1'b0;
        return;
      end
      push($sformatf("%s_e%0d", tag, e), (e >= 4) ? sel : old,
           (e == 8) ? mask : 4'h0, 4'h0, (e < 8), (e == 8));
      tick();
    end
    SW_REQ  = 1'b0;
    SEL_REQ = sel;
    QMASK   = mask;
  endtask

  // Low-power entry (edges 0..4), hold in LP, exit and mask restore.
  task automatic do_lp(input string tag, input logic ssel, input logic [3:0] saved,
                       input int hold, input logic early, input logic sw_poke);
    for (int e = 0; e <= 4; e++) begin
      SW_REQ = 1'b0;
      LP_REQ = (e == 0) ? 1'b1 : ~early;
      push($sformatf("%s_in%0d", tag, e), ssel, 4'h0, (e == 4) ? 4'hF : 4'h0, 1'b1, 1'b0);
      tick();
    end
    for (int h = 0; h < hold; h++) begin
      LP_REQ  = 1'b1;
      SW_REQ  = sw_poke && (h == 0);
      SEL_REQ = ~ssel;
      QMASK   = 4'h9;
      push($sformatf("%s_hold%0d", tag, h), ssel, 4'h0, 4'hF, 1'b1, 1'b0);
      tick();
    end
    SW_REQ  = 1'b0;
    SEL_REQ = ssel;
    for (int x = 0; x <= 4; x++) begin
      LP_REQ = 1'b0;
      push($sformatf("%s_out%0d", tag, x), ssel, (x == 4) ? saved : 4'h0,
           4'h0, (x < 4), (x == 4));
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST     = 1'b1;
    SW_REQ  = 1'b0;
    SEL_REQ = 1'b0;
    QMASK   = 4'h0;
    LP_REQ  = 1'b0;

    push("reset0", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    push("reset1", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;

    do_switch("sw_to_hsck", 1'b1, 4'hF, -1, -1, 1'b0);
    idle_edge("sw_to_hsck_e9", 1'b1, 4'hF);

    fast_switch("same_src", 1'b1, 4'h5);
    idle_edge("same_src_next", 1'b1, 4'h5);

    do_switch("sw_ignore", 1'b0, 4'h3, 2, -1, 1'b0);
    idle_edge("sw_ignore_e9", 1'b0, 4'h3);

    fast_switch("mask_a", 1'b0, 4'hA);
    idle_edge("mask_a_next", 1'b0, 4'hA);

    do_lp("lp", 1'b0, 4'hA, 2, 1'b0, 1'b1);
    idle_edge("lp_after", 1'b0, 4'hA);

    do_lp("lp_early", 1'b0, 4'hA, 0, 1'b1, 1'b0);
    idle_edge("lp_early_after", 1'b0, 4'hA);

    do_switch("sw_rst", 1'b1, 4'hF, -1, 5, 1'b0);
    idle_edge("sw_rst_after0", 1'b0, 4'h0);
    idle_edge("sw_rst_after1", 1'b0, 4'h0);

    do_switch("sw_lp", 1'b1, 4'h6, -1, -1, 1'b1);
    do_lp("sw_lp_lp", 1'b1, 4'h6, 1, 1'b0, 1'b0);
    idle_edge("sw_lp_after", 1'b1, 4'h6);

    do_switch("zero_mask", 1'b0, 4'h0, -1, -1, 1'b0);
    idle_edge("zero_mask_e9", 1'b0, 4'h0);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
